// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter in front of one registered bitwise logic unit.
// One op in flight: accept in IDLE, compute in EXEC, hold the result in RESP
// until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a request; grant offered combinationally
// EXEC  | operands latched; result registered at end of this cycle
// RESP  | rsp_valid held with stable data/id until rsp_ready
module logic_op_arbiter #(
  parameter int  WIDTH = 8,
  parameter int  N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]        op_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [ID_W-1:0]   id_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [WIDTH-1:0]  rsp_data_q;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W:0]     cand;
  logic              accept;
  logic [WIDTH-1:0]  result;

  // Round-robin search starting at rr_ptr; cand carries one extra bit so the
  // modulo wrap works for non power-of-two requester counts.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
    rr_ptr_d = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + ID_W'(1);
  end

  // Next state and handshake; req_ready is also masked by reset so that no
  // grant is visible while the block is held in reset.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_found && rst_n) begin
          accept               = 1'b1;
          req_ready[grant_idx] = 1'b1;
          state_d              = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shared logic unit on the latched operands.
  always_comb begin
    unique case (op_q)
      2'b00: result = a_q & b_q;
      2'b01: result = a_q | b_q;
      2'b10: result = a_q ^ b_q;
      2'b11: result = ~(a_q & b_q);
      default: result = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand latch, round-robin pointer and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      if (accept) begin
        op_q     <= req_op[2*grant_idx +: 2];
        a_q      <= req_a[WIDTH*grant_idx +: WIDTH];
        b_q      <= req_b[WIDTH*grant_idx +: WIDTH];
        id_q     <= grant_idx;
        rr_ptr_q <= rr_ptr_d;
      end
      if (state_q == EXEC) begin
        rsp_data_q  <= result;
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter: table of single-requester ops plus
// hand-written arbitration, backpressure, wrap and mid-op reset sequences.
module tb_logic_op_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  logic_op_arbiter #(.WIDTH(8), .N_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    int         id;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[2*i +: 2] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
  endtask

  // Returns as soon as req_ready is non-zero, sampling on negedges.
  task automatic wait_grant(input string name, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (req_ready != 4'b0) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    n_total++;
    $display("FAIL %s: no grant within 20 cycles, req_ready=%0h", name, req_ready);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int last_cyc;

    vecs[0] = '{0, 2'b00, 8'hF0, 8'h3C, 8'h30};
    vecs[1] = '{1, 2'b00, 8'hA5, 8'h0F, 8'h05};
    vecs[2] = '{2, 2'b01, 8'hA5, 8'h0F, 8'hAF};
    vecs[3] = '{3, 2'b10, 8'hA5, 8'h0F, 8'hAA};
    vecs[4] = '{0, 2'b11, 8'hA5, 8'h0F, 8'hFA};
    vecs[5] = '{1, 2'b10, 8'hFF, 8'h00, 8'hFF};
    vecs[6] = '{2, 2'b11, 8'hFF, 8'hFF, 8'h00};

    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset req_ready", 32'(req_ready), 0);
    chk("reset rsp_id", 32'(rsp_id), 0);
    chk("reset rsp_data", 32'(rsp_data), 0);
    rst_n = 1'b1;

    // Single-requester ops: grant, 2-cycle latency, result, return to IDLE.
    for (int v = 0; v < 7; v++) begin
      set_req(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b);
      req_valid[vecs[v].id] = 1'b1;
      #1;
      wait_grant($sformatf("vec%0d grant", v), ok);
      if (!ok) break;
      chk($sformatf("vec%0d ready", v), 32'(req_ready), 32'(1) << vecs[v].id);
      @(posedge clk);
      #1 req_valid[vecs[v].id] = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d exec rsp_valid", v), 32'(rsp_valid), 0);
      chk($sformatf("vec%0d exec busy", v), 32'(busy), 1);
      @(negedge clk);
      chk($sformatf("vec%0d rsp_valid", v), 32'(rsp_valid), 1);
      chk($sformatf("vec%0d rsp_id", v), 32'(rsp_id), 32'(vecs[v].id));
      chk($sformatf("vec%0d rsp_data", v), 32'(rsp_data), 32'(vecs[v].exp));
      @(negedge clk);
      chk($sformatf("vec%0d idle rsp_valid", v), 32'(rsp_valid), 0);
      chk($sformatf("vec%0d idle busy", v), 32'(busy), 0);
    end

    // All four valid from reset: order 0,1,2,3,0 at one grant per 3 cycles.
    for (int i = 0; i < 4; i++) set_req(i, 2'b10, 8'(i), 8'hF0);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("rr reset req_ready masked", 32'(req_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      wait_grant($sformatf("rr%0d grant", k), ok);
      if (!ok) break;
      chk($sformatf("rr%0d ready", k), 32'(req_ready), 32'(1) << e);
      if (k > 0) chk($sformatf("rr%0d spacing", k), 32'(cyc - last_cyc), 3);
      last_cyc = cyc;
      @(posedge clk);
      if (k == 4) #1 req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d rsp_valid", k), 32'(rsp_valid), 1);
      chk($sformatf("rr%0d rsp_id", k), 32'(rsp_id), 32'(e));
      chk($sformatf("rr%0d rsp_data", k), 32'(rsp_data), 32'(8'hF0 ^ 8'(e)));
    end
    @(negedge clk);

    // Backpressure: hold RESP for 5 cycles with req2 pending.
    rsp_ready = 1'b0;
    set_req(1, 2'b00, 8'hFF, 8'h5A);
    set_req(2, 2'b01, 8'h11, 8'h22);
    req_valid = 4'b0110;
    #1;
    wait_grant("bp grant", ok);
    chk("bp ready", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("bp%0d rsp_valid", s), 32'(rsp_valid), 1);
      chk($sformatf("bp%0d rsp_data", s), 32'(rsp_data), 32'h5A);
      chk($sformatf("bp%0d rsp_id", s), 32'(rsp_id), 1);
      chk($sformatf("bp%0d req_ready", s), 32'(req_ready), 0);
      chk($sformatf("bp%0d busy", s), 32'(busy), 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp release rsp_valid", 32'(rsp_valid), 0);
    chk("bp release busy", 32'(busy), 0);
    chk("bp release data held", 32'(rsp_data), 32'h5A);
    chk("bp release id held", 32'(rsp_id), 1);
    chk("bp next grant", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp req2 rsp_id", 32'(rsp_id), 2);
    chk("bp req2 rsp_data", 32'(rsp_data), 32'h33);
    @(negedge clk);

    // Wrap: rr_ptr is 3 now; req3 then req0.
    set_req(0, 2'b11, 8'h0F, 8'hF0);
    set_req(3, 2'b00, 8'h3C, 8'h0F);
    req_valid = 4'b1001;
    #1;
    wait_grant("wrap grant3", ok);
    chk("wrap ready3", 32'(req_ready), 32'h8);
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap rsp_id3", 32'(rsp_id), 3);
    chk("wrap rsp_data3", 32'(rsp_data), 32'h0C);
    wait_grant("wrap grant0", ok);
    chk("wrap ready0", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap rsp_id0", 32'(rsp_id), 0);
    chk("wrap rsp_data0", 32'(rsp_data), 32'hFF);
    @(negedge clk);

    // Reset during EXEC: op dropped, outputs cleared, pointer back to 0.
    set_req(2, 2'b10, 8'hFF, 8'h0F);
    req_valid = 4'b0100;
    #1;
    wait_grant("rst grant2", ok);
    chk("rst ready2", 32'(req_ready), 32'h4);
    @(posedge clk);
    #2;
    chk("rst pre busy", 32'(busy), 1);
    rst_n = 1'b0;
    set_req(0, 2'b01, 8'h01, 8'h02);
    set_req(3, 2'b00, 8'hFF, 8'hFF);
    req_valid = 4'b1101;
    #1;
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst req_ready", 32'(req_ready), 0);
    chk("rst rsp_data", 32'(rsp_data), 0);
    chk("rst rsp_id", 32'(rsp_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    wait_grant("rst grant0", ok);
    chk("rst ready0 first", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rst no stale rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("rst rsp_id0", 32'(rsp_id), 0);
    chk("rst rsp_data0", 32'(rsp_data), 32'h03);
    wait_grant("rst grant2b", ok);
    chk("rst ready2b", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst rsp_id2", 32'(rsp_id), 2);
    chk("rst rsp_data2", 32'(rsp_data), 32'hF0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
